draw_port_arbiter: RTL and testbench
====================================

// Module: draw_port_arbiter
// PURPOSE
//  Shares the single sprite-drawer write port between several draw requesters: moveSprite drawBG, moveSprite drawChar, the platform animator and the button/door animator.
//  Grants one requester at a time with round-robin priority.
//  Forwards the winner's coordinates and sprite ID to the drawer, then returns a 1-cycle done pulse to that requester only.
//  A watchdog releases the port if the drawer never reports completion.
// PARAMETERS
//  N_REQ    4      number of requesters (2..8)
//  XW       9      x coordinate width (320-wide screen)
//  YW       8      y coordinate width (240-high screen)
//  IDW      3      sprite ID width
//  TO_CYC   20'hFFFFF  watchdog limit, clock cycles spent in WAIT
// PORTS
//  clock       in   1          system clock
//  resetn      in   1          synchronous, active-low reset
//  req         in   N_REQ      level request; held high until own done pulse
//  req_x       in   N_REQ*XW   packed x per requester, slice i = [i*XW +: XW]
//  req_y       in   N_REQ*YW   packed y per requester
//  req_id      in   N_REQ*IDW  packed sprite ID per requester
//  done        out  N_REQ      1-cycle pulse to the owner at release (doneBG/doneChar)
//  drw_start   out  1          1-cycle start pulse to the sprite drawer
//  drw_x       out  XW         latched x, stable from START until the next grant
//  drw_y       out  YW         latched y
//  drw_id      out  IDW        latched sprite ID
//  drw_done    in   1          drawer completion pulse
//  busy        out  1          high in every state except IDLE
//  owner       out  3          index of current or last owner
//  timeout_err out  1          sticky; set on watchdog expiry
// BEHAVIOUR
//  Reset values
//  - All outputs 0; rr pointer 0; watchdog count 0; state IDLE.
//  - Reset mid-operation aborts the grant with no done pulse; drawer must be reset by the same resetn.
//  FSM: IDLE -> START -> WAIT -> RELEASE -> IDLE
//  - IDLE: if (req & ~mask) != 0, pick the winner and go to START.
//    - Winner = first set bit at or after ptr, searching upward with wrap at N_REQ.
//    - On the same edge, latch owner, drw_x, drw_y and drw_id from the winner's slice.
//  - START: drw_start = 1 for exactly one cycle; clear watchdog; go to WAIT.
//  - WAIT
//    - drw_done = 1 -> RELEASE.
//    - else, watchdog == TO_CYC-1 -> set timeout_err, go to RELEASE.
//    - else, watchdog increments.
//  - RELEASE: done[owner] = 1 for one cycle; ptr <= (owner+1) mod N_REQ; mask <= onehot(owner); go to IDLE.
//  Mask
//  - mask suppresses the just-served requester for exactly the first IDLE cycle, then clears.
//  - Purpose: stops a re-grant before the requester's FSM has dropped req.
//  Latency and handshake
//  - req rising in IDLE at cycle t -> drw_start at t+1.
//  - drw_done at cycle u in WAIT -> done[owner] at u+1.
//  - Back-to-back grants: minimum 4 cycles per draw plus drawer time.
//  - drw_done outside WAIT is ignored (no state change, no error).
//  - Simultaneous drw_done and watchdog expiry: drw_done wins; timeout_err stays unchanged.
//  - A requester that drops req while owning is still served to completion; its coordinates are already latched.
//  - Requests arriving while busy wait; nothing is queued beyond the level req.
//  - Coordinates are not range-checked; legality belongs to the movement datapath.
//  Width rules
//  - ptr and owner are 3 bits; wrap computed as (owner == N_REQ-1) ? 0 : owner+1.
//  - Watchdog is 20 bits, saturating.
// STRUCTURE
//  - Shared include draw_defs.vh holds:
//    - sprite ID constants (SPR_BG, SPR_CHAR, SPR_PLATFORM, SPR_DOOR);
//    - requester index constants (REQ_BG=0, REQ_CHAR=1, REQ_PLAT=2, REQ_DOOR=3);
//    - arbiter state encodings.
//  - One sub-module: rr_pick (combinational).
//    - Inputs: req_masked[N_REQ], ptr.
//    - Outputs: winner index and any_valid.
//  - FSM, latches, mask and watchdog stay in this module.
// TESTING
//  - Single request: req=4'b0001, x=95, y=221, id=SPR_BG.
//    -> drw_start 1 cycle later with drw_x=95, drw_y=221.
//    -> drw_done after 10 cycles -> done=4'b0001 one cycle later; busy low afterward.
//  - Contention: req=4'b1111 held, drawer done after 3 cycles each.
//    -> grant order 0,1,2,3,0; no requester is granted twice before all others are served.
//  - moveSprite pairing: BG then char at (96,220).
//    -> done[0] pulses once, then drw_start for requester 1 carries x=96, y=220.
//    -> no second grant to requester 0 within its mask cycle.
//  - Watchdog: TO_CYC=16, drw_done never asserted.
//    -> done[owner] 17 cycles after drw_start, timeout_err=1 and sticky.
//    -> next grant proceeds normally.
//  - Coincident events: drw_done pulse during START -> ignored, FSM stays in WAIT.
//  - Coincident events: drw_done on the same cycle the watchdog expires -> timeout_err stays 0.
//  - Reset in WAIT: resetn=0 for one cycle -> all outputs 0, no done pulse, ptr=0.

Source files
------------

// File: rtl/draw_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// draw_port_arbiter_pkg
// Shared definitions for the sprite-drawer port arbiter:
//   - sprite ID constants handed to the drawer
//   - requester index constants (bit position in the req vector)
//   - arbiter FSM state encoding
//   - round-robin pointer advance helper
// -----------------------------------------------------------------------------
package draw_port_arbiter_pkg;

  // Sprite IDs understood by the sprite drawer
  localparam logic [2:0] SPR_BG       = 3'd0;
  localparam logic [2:0] SPR_CHAR     = 3'd1;
  localparam logic [2:0] SPR_PLATFORM = 3'd2;
  localparam logic [2:0] SPR_DOOR     = 3'd3;

  // Requester positions in the req / done vectors
  localparam int REQ_BG   = 0;
  localparam int REQ_CHAR = 1;
  localparam int REQ_PLAT = 2;
  localparam int REQ_DOOR = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

  // Next round-robin start position: one past the last owner, wrapping at n_req
  function automatic logic [2:0] next_ptr(input logic [2:0] cur, input int n_req);
    logic [2:0] nxt;
    if (cur == 3'(n_req - 1)) begin
      nxt = 3'd0;
    end else begin
      nxt = cur + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/draw_port_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// draw_port_arbiter_rr_pick
// Combinational round-robin selector. Finds the first set bit of req_masked
// at or after position ptr, searching upward and wrapping at N_REQ.
// Ports:
//   req_masked  in  N_REQ  eligible requests (already masked by the caller)
//   ptr         in  3      search start position (0..N_REQ-1)
//   winner      out 3      index of the selected requester (0 when none)
//   any_valid   out 1      high when at least one request is eligible
// -----------------------------------------------------------------------------
module draw_port_arbiter_rr_pick
  import draw_port_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req_masked,
  input  logic [2:0]       ptr,
  output logic [2:0]       winner,
  output logic             any_valid
);

  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  logic [3:0] idx;
  logic       hit;

  // Scan offsets from farthest to nearest so the nearest hit is the last write
  always_comb begin
    winner    = 3'd0;
    any_valid = 1'b0;
    idx       = 4'd0;
    hit       = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx       = {1'b0, ptr} + 4'(k);
      idx       = (idx >= 4'(N_REQ)) ? (idx - 4'(N_REQ)) : idx;
      hit       = ((req_masked & (ONE << idx)) != {N_REQ{1'b0}});
      winner    = hit ? idx[2:0] : winner;
      any_valid = any_valid | hit;
    end
  end

endmodule

// File: rtl/draw_port_arbiter.sv
// -----------------------------------------------------------------------------
// draw_port_arbiter
// Shares the single sprite-drawer write port between the draw requesters
// (background, character, platform animator, button/door animator).
// One requester is granted at a time in round-robin order; its coordinates
// and sprite ID are latched and forwarded to the drawer with a 1-cycle start
// pulse, and a 1-cycle done pulse goes back to that requester alone when the
// drawer finishes. A watchdog releases the port if the drawer never answers.
// Ports:
//   clock        in   1          system clock
//   resetn       in   1          synchronous, active-low reset
//   req          in   N_REQ      level requests, held until own done pulse
//   req_x        in   N_REQ*XW   packed x per requester, slice i = [i*XW +: XW]
//   req_y        in   N_REQ*YW   packed y per requester
//   req_id       in   N_REQ*IDW  packed sprite ID per requester
//   done         out  N_REQ      1-cycle pulse to the owner at release
//   drw_start    out  1          1-cycle start pulse to the drawer
//   drw_x/y/id   out  XW/YW/IDW  latched coordinates / sprite ID of the owner
//   drw_done     in   1          drawer completion pulse (only honoured in WAIT)
//   busy         out  1          high in every state except IDLE
//   owner        out  3          index of current or last owner
//   timeout_err  out  1          sticky watchdog-expiry flag
// -----------------------------------------------------------------------------
module draw_port_arbiter
  import draw_port_arbiter_pkg::*;
#(
  parameter int          N_REQ  = 4,
  parameter int          XW     = 9,
  parameter int          YW     = 8,
  parameter int          IDW    = 3,
  parameter logic [19:0] TO_CYC = 20'hFFFFF
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*XW-1:0]  req_x,
  input  logic [N_REQ*YW-1:0]  req_y,
  input  logic [N_REQ*IDW-1:0] req_id,
  output logic [N_REQ-1:0]     done,
  output logic                 drw_start,
  output logic [XW-1:0]        drw_x,
  output logic [YW-1:0]        drw_y,
  output logic [IDW-1:0]       drw_id,
  input  logic                 drw_done,
  output logic                 busy,
  output logic [2:0]           owner,
  output logic                 timeout_err
);

  localparam logic [N_REQ-1:0] ONE     = N_REQ'(1);
  localparam logic [19:0]      WD_LAST = TO_CYC - 20'd1;
  localparam logic [19:0]      WD_MAX  = 20'hFFFFF;

  arb_state_t       state;
  logic [2:0]       ptr;
  logic [N_REQ-1:0] mask;
  logic [19:0]      wd;

  logic [N_REQ-1:0] req_masked;
  logic [2:0]       winner;
  logic             any_valid;
  logic [XW-1:0]    sel_x;
  logic [YW-1:0]    sel_y;
  logic [IDW-1:0]   sel_id;

  // The just-served requester is hidden for one IDLE cycle so a requester
  // that has not yet dropped req is not granted again straight away.
  always_comb begin
    req_masked = req & ~mask;
    sel_x      = XW'(req_x >> (32'(winner) * XW));
    sel_y      = YW'(req_y >> (32'(winner) * YW));
    sel_id     = IDW'(req_id >> (32'(winner) * IDW));
  end

  draw_port_arbiter_rr_pick #(
    .N_REQ (N_REQ)
  ) u_rr_pick (
    .req_masked (req_masked),
    .ptr        (ptr),
    .winner     (winner),
    .any_valid  (any_valid)
  );

  // Arbiter FSM with registered handshake outputs, mask and watchdog
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      ptr         <= 3'd0;
      mask        <= {N_REQ{1'b0}};
      wd          <= 20'd0;
      done        <= {N_REQ{1'b0}};
      drw_start   <= 1'b0;
      drw_x       <= {XW{1'b0}};
      drw_y       <= {YW{1'b0}};
      drw_id      <= {IDW{1'b0}};
      busy        <= 1'b0;
      owner       <= 3'd0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= {N_REQ{1'b0}};
          mask <= {N_REQ{1'b0}};
          if (any_valid) begin
            owner     <= winner;
            drw_x     <= sel_x;
            drw_y     <= sel_y;
            drw_id    <= sel_id;
            drw_start <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_START;
          end else begin
            drw_start <= 1'b0;
            busy      <= 1'b0;
          end
        end
        ST_START: begin
          drw_start <= 1'b0;
          wd        <= 20'd0;
          state     <= ST_WAIT;
        end
        ST_WAIT: begin
          // Drawer completion takes precedence over a coincident expiry
          if (drw_done) begin
            done  <= ONE << owner;
            state <= ST_RELEASE;
          end else if (wd == WD_LAST) begin
            done        <= ONE << owner;
            timeout_err <= 1'b1;
            state       <= ST_RELEASE;
          end else if (wd != WD_MAX) begin
            wd <= wd + 20'd1;
          end
        end
        ST_RELEASE: begin
          done  <= {N_REQ{1'b0}};
          ptr   <= next_ptr(owner, N_REQ);
          mask  <= ONE << owner;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          done      <= {N_REQ{1'b0}};
          drw_start <= 1'b0;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_draw_port_arbiter
// Self-checking bench for draw_port_arbiter. Requesters and the drawer are
// modelled at transaction level: each grant's expected owner is the first
// pending requester at or after the round-robin pointer, and expected pulse
// timings are computed from the handshake latencies. Outputs are sampled on
// the falling edge; inputs are driven right after sampling.
// -----------------------------------------------------------------------------
module tb_draw_port_arbiter;
  import draw_port_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int XW  = 9;
  localparam int YW  = 8;
  localparam int IDW = 3;
  localparam int TO  = 16;

  logic             clock;
  logic             resetn;
  logic [N-1:0]     req;
  logic [N*XW-1:0]  req_x;
  logic [N*YW-1:0]  req_y;
  logic [N*IDW-1:0] req_id;
  logic [N-1:0]     done;
  logic             drw_start;
  logic [XW-1:0]    drw_x;
  logic [YW-1:0]    drw_y;
  logic [IDW-1:0]   drw_id;
  logic             drw_done;
  logic             busy;
  logic [2:0]       owner;
  logic             timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int             m_ptr;
  bit             m_err;
  int             m_owner;
  logic [XW-1:0]  m_x;
  logic [YW-1:0]  m_y;
  logic [IDW-1:0] m_id;
  bit             grow_en;
  int             extra;

  draw_port_arbiter #(
    .N_REQ  (N),
    .XW     (XW),
    .YW     (YW),
    .IDW    (IDW),
    .TO_CYC (20'd16)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .req         (req),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_id      (req_id),
    .done        (done),
    .drw_start   (drw_start),
    .drw_x       (drw_x),
    .drw_y       (drw_y),
    .drw_id      (drw_id),
    .drw_done    (drw_done),
    .busy        (busy),
    .owner       (owner),
    .timeout_err (timeout_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic int rr_first(input logic [N-1:0] cand, input int from);
    int i;
    for (int k = 0; k < N; k++) begin
      i = (from + k) % N;
      if (cand[i]) return i;
    end
    return -1;
  endfunction

  task automatic set_coords(input int i, input int x, input int y, input int id);
    req_x[i*XW +: XW]   = XW'(x);
    req_y[i*YW +: YW]   = YW'(y);
    req_id[i*IDW +: IDW] = IDW'(id);
  endtask

  task automatic raise(input int i);
    set_coords(i, int'($urandom_range(0, 319)), int'($urandom_range(0, 239)),
               int'($urandom_range(0, 7)));
    req[i] = 1'b1;
  endtask

  // Wait for drw_start; 'already' = falling edges elapsed since the reference point
  task automatic wait_start(input int already, input int exp_lat, input int exp_win);
    int n;
    n = already;
    while (drw_start !== 1'b1 && n < 8) begin
      @(negedge clock);
      n++;
    end
    check_eq("start_latency", 64'(n), 64'(exp_lat));
    check_eq("grant_owner", 64'(owner), 64'(exp_win));
    m_owner = exp_win;
    m_x  = req_x[exp_win*XW +: XW];
    m_y  = req_y[exp_win*YW +: YW];
    m_id = req_id[exp_win*IDW +: IDW];
    check_eq("drw_coords", 64'({drw_x, drw_y, drw_id}), 64'({m_x, m_y, m_id}));
    check_eq("busy_start", 64'(busy), 64'd1);
  endtask

  // Drawer answers d falling edges after start (d outside 1..TO: never answers).
  // post: 0 drop req at done, 1 drop two edges later, 2 keep holding, 3 drop all.
  task automatic serve(input int d, input bit spurious, input int post,
                       input bit drop_mid, output int ext);
    int           j;
    bit           got;
    int           win;
    bit           answers;
    logic [N-1:0] onehot;
    win     = m_owner;
    answers = (d >= 1 && d <= TO);
    j       = 0;
    got     = 1'b0;
    drw_done = spurious;
    while (!got && j < 40) begin
      @(negedge clock);
      j++;
      if (done !== {N{1'b0}}) begin
        got = 1'b1;
      end else begin
        if (j == 1) begin
          if (grow_en) begin
            for (int i = 0; i < N; i++)
              if (i != win && !req[i] && $urandom_range(0, 2) == 0) raise(i);
          end
          if (drop_mid) begin
            req[win] = 1'b0;
            req_x[win*XW +: XW] = ~m_x;
          end
        end
        drw_done = (j == d);
      end
    end
    drw_done = 1'b0;
    check_eq("done_latency", 64'(j), 64'(answers ? d + 1 : TO + 1));
    onehot = N'(1) << win;
    check_eq("done_vector", 64'(done), 64'(onehot));
    if (!answers) m_err = 1'b1;
    check_eq("timeout_err", 64'(timeout_err), 64'(m_err));
    check_eq("coords_held", 64'({drw_x, drw_y, drw_id}), 64'({m_x, m_y, m_id}));
    m_ptr = (win + 1) % N;
    ext = 0;
    if (post == 0) begin
      req[win] = 1'b0;
    end else if (post == 1) begin
      @(negedge clock);
      ext = 1;
      check_eq("done_width", 64'(done), 64'd0);
      @(negedge clock);
      ext = 2;
      req[win] = 1'b0;
    end else if (post == 3) begin
      req = '0;
    end
  endtask

  // Predict and check the grant following a release
  task automatic follow(input int ext);
    logic [N-1:0] others;
    logic [N-1:0] s;
    int           win;
    win    = m_owner;
    others = req;
    others[win] = 1'b0;
    if (others != '0) begin
      wait_start(ext, 2, rr_first(others, m_ptr));
    end else if (req[win]) begin
      wait_start(ext, 3, win);
    end else begin
      repeat ($urandom_range(2, 3)) begin
        @(negedge clock);
        check_eq("idle_quiet", 64'({busy, drw_start}), 64'd0);
      end
      s = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) if (s[i]) raise(i);
      wait_start(0, 1, rr_first(req, m_ptr));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    resetn = 1'b0; req = '0; req_x = '0; req_y = '0; req_id = '0; drw_done = 1'b0;
    m_ptr = 0; m_err = 1'b0; m_owner = 0; grow_en = 1'b0;
    repeat (2) @(negedge clock);
    check_eq("reset_state", 64'({done, drw_start, drw_x, drw_y, drw_id, busy, owner, timeout_err}), 64'd0);
    resetn = 1'b1;
    @(negedge clock);

    // Single background request
    set_coords(REQ_BG, 95, 221, int'(SPR_BG));
    req[REQ_BG] = 1'b1;
    wait_start(0, 1, REQ_BG);
    check_eq("single_xy", 64'({drw_x, drw_y}), 64'({9'd95, 8'd221}));
    serve(10, 1'b0, 0, 1'b0, extra);
    repeat (2) begin
      @(negedge clock);
      check_eq("single_idle", 64'({busy, done}), 64'd0);
    end

    // Reset while waiting on the drawer
    raise(REQ_PLAT);
    wait_start(0, 1, rr_first(req, m_ptr));
    repeat (3) @(negedge clock);
    resetn = 1'b0; req = '0;
    @(negedge clock);
    check_eq("reset_in_wait", 64'({done, drw_start, drw_x, drw_y, drw_id, busy, owner, timeout_err}), 64'd0);
    resetn = 1'b1; m_ptr = 0; m_err = 1'b0;
    @(negedge clock);
    check_eq("reset_no_done", 64'({done, busy}), 64'd0);

    // Full contention, all requests held: order 0,1,2,3,0,1,2,3
    for (int i = 0; i < N; i++) raise(i);
    wait_start(0, 1, rr_first(req, m_ptr));
    for (int g = 0; g < 8; g++) begin
      serve(3, 1'b0, (g == 7) ? 3 : 2, 1'b0, extra);
      if (g < 7) follow(extra);
    end
    repeat (2) @(negedge clock);

    // Background then character at (96,220); BG keeps req one cycle after done
    raise(REQ_BG);
    set_coords(REQ_CHAR, 96, 220, int'(SPR_CHAR));
    req[REQ_CHAR] = 1'b1;
    wait_start(0, 1, REQ_BG);
    serve(4, 1'b0, 1, 1'b0, extra);
    follow(extra);
    check_eq("pair_xy", 64'({drw_x, drw_y}), 64'({9'd96, 8'd220}));
    serve(5, 1'b0, 0, 1'b0, extra);

    // Spurious drw_done in START, then drw_done coincident with expiry
    follow(extra);
    serve(TO, 1'b1, 0, 1'b0, extra);
    // Drawer never answers: watchdog release, sticky error, next grant normal
    follow(extra);
    serve(0, 1'b0, 0, 1'b0, extra);
    follow(extra);
    serve(5, 1'b0, 0, 1'b0, extra);

    // Randomised traffic
    grow_en = 1'b1;
    follow(extra);
    for (int t = 0; t < 60; t++) begin
      int d;
      d = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TO));
      serve(d, 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
            ($urandom_range(0, 3) == 0), extra);
      follow(extra);
    end
    serve(2, 1'b0, 3, 1'b0, extra);
    @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
